// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, talks req/ack to imem and
// feeds decode from a 2-entry buffer. IFU_STAT_EN adds fetch/flush counters.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] pc,
    output logic        misalign
`ifdef IFU_STAT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DROP = 2'd1,
        S_IDLE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] saved_pc;
    logic        misalign_q;
    logic [1:0]  count;
    logic [1:0]  count_next;

    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] head_pc4;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;

    logic        ack;
    logic        pop;
    logic        push;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign ack      = imem_ack & (state != S_IDLE);
    assign id_valid = (count != 2'd0);
    assign pop      = id_valid & id_ready;
    assign push     = (state == S_REQ) & ack & ~redirect;
    assign target   = {redirect_pc[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    assign imem_req  = reset & (state != S_IDLE);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign misalign  = misalign_q;
    assign id_instr  = head_instr;
    assign id_pc     = head_pc;
    assign id_pc4    = head_pc4;

    // Next buffer occupancy; a redirect flushes and swallows any pop.
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Fetch FSM: PC, pending redirect target and sticky misalign flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_REQ;
            pc_q       <= RESET_PC;
            saved_pc   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
            case (state)
                S_REQ: begin
                    if (redirect) begin
                        if (ack) begin
                            pc_q <= target;
                        end else begin
                            saved_pc <= target;
                            state    <= S_DROP;
                        end
                    end else if (ack) begin
                        pc_q <= pc_plus4;
                        if (count_next == 2'd2) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (ack) begin
                        pc_q  <= redirect ? target : saved_pc;
                        state <= S_REQ;
                    end else if (redirect) begin
                        saved_pc <= target;
                    end
                end
                S_IDLE: begin
                    if (redirect) begin
                        pc_q  <= target;
                        state <= S_REQ;
                    end else if (pop) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Two-entry buffer: head drives decode, tail shifts in on pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= 2'd0;
            head_instr <= 32'd0;
            head_pc    <= 32'd0;
            head_pc4   <= 32'd0;
            tail_instr <= 32'd0;
            tail_pc    <= 32'd0;
        end else begin
            count <= count_next;
            if (!redirect) begin
                if (push && ((count == 2'd0) ||
                             ((count == 2'd1) && pop))) begin
                    head_instr <= imem_rdata;
                    head_pc    <= pc_q;
                    head_pc4   <= pc_plus4;
                end else if (pop && (count == 2'd2)) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    head_pc4   <= tail_pc + 32'd4;
                end
                if (push && (count == 2'd1) && !pop) begin
                    tail_instr <= imem_rdata;
                    tail_pc    <= pc_q;
                end
            end
        end
    end

`ifdef IFU_STAT_EN
    // Event counters: pushes and redirect cycles, wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (push) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
